aes_stream_adapter: RTL and testbench

- Parametrised streaming front-end for the iterative AES-128 core.
- Replaces the fixed two-beat 64-bit Start/DATA/KEY loading scheme with a valid/ready interface of configurable bus width.
- Assembles 128-bit block and key from BUS_W-bit beats, launches the core and waits for completion with a timeout.
- Returns result and final round key as BUS_W-bit beats with backpressure. Sits between the system bus and the AES core; carries the encrypt/decrypt mode bit.

---
 rtl/aes_stream_adapter_if.sv | 21 ++
 rtl/aes_stream_adapter.sv | 97 +++++++++
 tb/tb_aes_stream_adapter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_adapter_if.sv
// aes_stream_adapter_if: valid/ready beat streams between the system bus and the AES stream adapter
interface aes_stream_adapter_if #(parameter int BUS_W = 64);
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic [BUS_W-1:0] in_key;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic [BUS_W-1:0] out_key;
  logic             out_last;
  modport master (
    output in_valid, in_data, in_key, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_key, out_last
  );
  modport slave (
    input  in_valid, in_data, in_key, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_key, out_last
  );
endinterface

// File: rtl/aes_stream_adapter.sv
// aes_stream_adapter: assembles BUS_W-bit beats into an AES-128 block/key, runs the core with a timeout,
// and streams result and final round key back out as BUS_W-bit beats under backpressure
module aes_stream_adapter #(
  parameter int BUS_W   = 64,
  parameter int TIMEOUT = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  aes_stream_adapter_if.slave  s,
  output logic                 core_start,
  output logic                 core_mode,
  output logic [127:0]         core_block,
  output logic [127:0]         core_key,
  input  logic                 core_done,
  input  logic [127:0]         core_result,
  input  logic [127:0]         core_key_out,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int NBEATS = 128 / BUS_W;
  localparam logic [1:0] LAST = 2'(NBEATS - 1);
  typedef enum logic [1:0] {LOAD, LAUNCH, WAIT, SEND} state_t;
  state_t       state_q;
  logic [1:0]   bcnt_q;
  logic [7:0]   tcnt_q;
  logic [127:0] blk_q, key_q, res_q, rkey_q;
  logic         mode_q, start_q, terr_q, oval_q;
  logic [6:0]   ld_hi;
  assign ld_hi         = 7'(127 - BUS_W * int'(bcnt_q));
  assign s.in_ready    = state_q == LOAD;
  assign s.out_valid   = oval_q;
  assign s.out_data    = res_q[127 -: BUS_W];
  assign s.out_key     = rkey_q[127 -: BUS_W];
  assign s.out_last    = oval_q & (bcnt_q == LAST);
  assign core_start    = start_q;
  assign core_mode     = mode_q;
  assign core_block    = blk_q;
  assign core_key      = key_q;
  assign busy          = state_q != LOAD;
  assign timeout_err   = terr_q;
  // tcnt_q counts cycles elapsed since the core_start cycle; abort is decided in cycle TIMEOUT-1
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= LOAD;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      blk_q   <= '0;
      key_q   <= '0;
      res_q   <= '0;
      rkey_q  <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      terr_q  <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        LOAD: if (s.in_valid) begin
          blk_q[ld_hi -: BUS_W] <= s.in_data;
          key_q[ld_hi -: BUS_W] <= s.in_key;
          if (bcnt_q == 2'd0) mode_q <= s.in_mode;
          bcnt_q <= bcnt_q == LAST ? 2'd0 : bcnt_q + 2'd1;
          if (bcnt_q == LAST) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
          end
        end
        LAUNCH: begin
          tcnt_q  <= 8'd1;
          state_q <= WAIT;
        end
        WAIT: begin
          tcnt_q <= tcnt_q + 8'd1;
          if (core_done) begin
            res_q   <= core_result;
            rkey_q  <= core_key_out;
            oval_q  <= 1'b1;
            state_q <= SEND;
          end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
            terr_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        SEND: if (s.out_ready) begin
          res_q  <= res_q << BUS_W;
          rkey_q <= rkey_q << BUS_W;
          bcnt_q <= bcnt_q == LAST ? 2'd0 : bcnt_q + 2'd1;
          if (bcnt_q == LAST) begin
            oval_q  <= 1'b0;
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_adapter.sv
// tb_aes_stream_adapter: directed checks of the AES stream adapter at 64-, 32- and 128-bit beat widths
module tb_aes_stream_adapter;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [127:0] res = '0, rk = '0;
  aes_stream_adapter_if #(.BUS_W(64))  ia();
  aes_stream_adapter_if #(.BUS_W(32))  ib();
  aes_stream_adapter_if #(.BUS_W(128)) ic();
  logic         start_a, mode_a, done_a = 1'b0, busy_a, terr_a;
  logic         start_b, mode_b, done_b = 1'b0, busy_b, terr_b;
  logic         start_c, mode_c, done_c = 1'b0, busy_c, terr_c;
  logic [127:0] blk_a, key_a, blk_b, key_b, blk_c, key_c;
  aes_stream_adapter #(.BUS_W(64), .TIMEOUT(16)) u_a (
    .CLK(clk), .reset(reset), .s(ia), .core_start(start_a), .core_mode(mode_a),
    .core_block(blk_a), .core_key(key_a), .core_done(done_a), .core_result(res),
    .core_key_out(rk), .busy(busy_a), .timeout_err(terr_a));
  aes_stream_adapter #(.BUS_W(32), .TIMEOUT(32)) u_b (
    .CLK(clk), .reset(reset), .s(ib), .core_start(start_b), .core_mode(mode_b),
    .core_block(blk_b), .core_key(key_b), .core_done(done_b), .core_result(res),
    .core_key_out(rk), .busy(busy_b), .timeout_err(terr_b));
  aes_stream_adapter #(.BUS_W(128), .TIMEOUT(32)) u_c (
    .CLK(clk), .reset(reset), .s(ic), .core_start(start_c), .core_mode(mode_c),
    .core_block(blk_c), .core_key(key_c), .core_done(done_c), .core_result(res),
    .core_key_out(rk), .busy(busy_c), .timeout_err(terr_c));
  int checks = 0, errors = 0, nstart_a = 0, ov_a = 0;
  always @(posedge clk) begin
    if (start_a) nstart_a++;
    if (ia.out_valid) ov_a++;
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // two beats, MSB first; in_mode flips on beat 1 to prove it is ignored there
  task automatic load_a(logic [127:0] b, logic [127:0] k, logic m);
    ia.in_valid = 1'b1;
    ia.in_data  = b[127:64];
    ia.in_key   = k[127:64];
    ia.in_mode  = m;
    tick();
    ia.in_data  = b[63:0];
    ia.in_key   = k[63:0];
    ia.in_mode  = ~m;
    tick();
    ia.in_valid = 1'b0;
  endtask
  task automatic run_a(logic [127:0] b, logic [127:0] k, logic m, logic [127:0] r, logic [127:0] rkey, int lat);
    load_a(b, k, m);
    chk("a_start", start_a, 1);
    chk("a_block", blk_a, b);
    chk("a_key", key_a, k);
    chk("a_mode", mode_a, m);
    chk("a_in_ready_launch", ia.in_ready, 0);
    tick(lat);
    chk("a_busy_wait", busy_a, 1);
    chk("a_start_once", start_a, 0);
    res = r;
    rk = rkey;
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    chk("a_ov0", ia.out_valid, 1);
    chk("a_od0", ia.out_data, r[127:64]);
    chk("a_ok0", ia.out_key, rkey[127:64]);
    chk("a_last0", ia.out_last, 0);
    tick();
    chk("a_ov0_hold", ia.out_valid, 1);
    chk("a_od0_hold", ia.out_data, r[127:64]);
    ia.out_ready = 1'b1;
    tick();
    chk("a_od1", ia.out_data, r[63:0]);
    chk("a_ok1", ia.out_key, rkey[63:0]);
    chk("a_last1", ia.out_last, 1);
    tick();
    ia.out_ready = 1'b0;
    chk("a_ov_drop", ia.out_valid, 0);
    chk("a_in_ready_back", ia.in_ready, 1);
    chk("a_busy_idle", busy_a, 0);
  endtask
  initial begin
    int ov0, idx;
    logic [3:0] pat;
    ia.in_valid = 0; ia.in_data = '0; ia.in_key = '0; ia.in_mode = 0; ia.out_ready = 0;
    ib.in_valid = 0; ib.in_data = '0; ib.in_key = '0; ib.in_mode = 0; ib.out_ready = 0;
    ic.in_valid = 0; ic.in_data = '0; ic.in_key = '0; ic.in_mode = 0; ic.out_ready = 0;
    tick(2);
    reset = 1'b0;
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_last", ia.out_last, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_terr", terr_a, 0);
    chk("rst_start", start_a, 0);
    chk("rst_block", blk_a, 0);
    chk("rst_out_data", ia.out_data, 0);
    // encrypt, core answers 10 cycles after launch
    run_a(PT, KEY, 1'b0, CT, RK, 10);
    chk("a_start_count", nstart_a, 1);
    // decrypt
    run_a(CT, RK, 1'b1, PT, KEY, 3);
    // timeout with a silent core
    ov0 = ov_a;
    load_a(PT, KEY, 1'b0);
    chk("to_start", start_a, 1);
    tick(15);
    chk("to_terr_early", terr_a, 0);
    chk("to_busy_early", busy_a, 1);
    tick();
    chk("to_terr", terr_a, 1);
    chk("to_in_ready", ia.in_ready, 1);
    chk("to_busy", busy_a, 0);
    tick(3);
    chk("to_no_output", ov_a, ov0);
    run_a(PT, KEY, 1'b0, CT, RK, 5);
    chk("to_terr_sticky", terr_a, 1);
    // reset during WAIT with a coincident core_done
    ov0 = ov_a;
    load_a(PT, KEY, 1'b0);
    tick(3);
    reset = 1'b1;
    done_a = 1'b1;
    tick();
    reset = 1'b0;
    done_a = 1'b0;
    chk("rw_in_ready", ia.in_ready, 1);
    chk("rw_out_valid", ia.out_valid, 0);
    chk("rw_busy", busy_a, 0);
    chk("rw_terr", terr_a, 0);
    chk("rw_block", blk_a, 0);
    tick(4);
    chk("rw_no_output", ov_a, ov0);
    chk("rw_busy_late", busy_a, 0);
    // 32-bit beats with random valid gaps
    for (int i = 0; i < 4; i++) begin
      ib.in_valid = 1'b0;
      tick($urandom_range(0, 2));
      ib.in_valid = 1'b1;
      ib.in_data  = PT[127 - 32*i -: 32];
      ib.in_key   = KEY[127 - 32*i -: 32];
      tick();
    end
    ib.in_valid = 1'b0;
    chk("b_start", start_b, 1);
    chk("b_block", blk_b, PT);
    chk("b_key", key_b, KEY);
    tick(2);
    res = CT;
    rk = RK;
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    pat = 4'b1001;
    idx = 0;
    for (int c = 0; c < 24 && idx < 4; c++) begin
      chk("b_ov", ib.out_valid, 1);
      chk("b_od", ib.out_data, CT[127 - 32*idx -: 32]);
      chk("b_ok", ib.out_key, RK[127 - 32*idx -: 32]);
      chk("b_last", ib.out_last, idx == 3);
      ib.out_ready = pat[c % 4];
      if (ib.out_ready) idx++;
      tick();
    end
    ib.out_ready = 1'b0;
    chk("b_beats", idx, 4);
    chk("b_ov_drop", ib.out_valid, 0);
    // single 128-bit beat
    ic.in_valid = 1'b1;
    ic.in_data  = PT;
    ic.in_key   = KEY;
    tick();
    ic.in_valid = 1'b0;
    chk("c_start", start_c, 1);
    chk("c_block", blk_c, PT);
    chk("c_key", key_c, KEY);
    tick();
    done_c = 1'b1;
    tick();
    done_c = 1'b0;
    chk("c_ov", ic.out_valid, 1);
    chk("c_od", ic.out_data, CT);
    chk("c_ok", ic.out_key, RK);
    chk("c_last", ic.out_last, 1);
    ic.out_ready = 1'b1;
    tick();
    ic.out_ready = 1'b0;
    chk("c_ov_drop", ic.out_valid, 0);
    chk("c_in_ready", ic.in_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
